// File: rtl/mmu_tlb_if.sv
// Translation request/response bus for mmu_tlb: per-channel request strobe and address,
// plus a registered result with its own ready handshake.
interface mmu_tlb_if #(
  parameter int NUM_CH = 2
) ();
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH-1:0][31:0] req_vaddr;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH-1:0]       resp_valid;
  logic [NUM_CH-1:0]       resp_ready;
  logic [NUM_CH-1:0][31:0] resp_paddr;
  logic [NUM_CH-1:0]       resp_cached;
  logic [NUM_CH-1:0]       resp_miss;

  modport master (
    output req_valid, req_vaddr, resp_ready,
    input  req_ready, resp_valid, resp_paddr, resp_cached, resp_miss
  );

  modport slave (
    input  req_valid, req_vaddr, resp_ready,
    output req_ready, resp_valid, resp_paddr, resp_cached, resp_miss
  );
endinterface

// File: rtl/mmu_tlb.sv
// Multi-channel address translation: fixed kseg0/kseg1 windows plus a shared fully-associative TLB.
// Each channel owns a one-deep result register; the TLB is read by all channels in parallel.
module mmu_tlb_ch #(
  parameter int TLB_ENTRIES  = 8,
  parameter int KSEG0_CACHED = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [31:0]                 req_vaddr,
  output logic                        req_ready,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [31:0]                 resp_paddr,
  output logic                        resp_cached,
  output logic                        resp_miss,
  output logic [15:0]                 miss_count,
  input  logic [TLB_ENTRIES-1:0][19:0] ent_vpn,
  input  logic [TLB_ENTRIES-1:0][19:0] ent_pfn,
  input  logic [TLB_ENTRIES-1:0]       ent_v,
  input  logic [TLB_ENTRIES-1:0]       ent_c
);
  logic        hit, hit_c;
  logic [19:0] hit_pfn;
  logic [31:0] nxt_paddr;
  logic        nxt_cached, nxt_miss, acc;

  assign req_ready = !resp_valid || resp_ready;
  assign acc       = req_valid && req_ready;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_c   = 1'b0;
    hit_pfn = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (ent_v[i] && ent_vpn[i] == req_vaddr[31:12]) begin
        hit     = 1'b1;
        hit_c   = ent_c[i];
        hit_pfn = ent_pfn[i];
      end
    end
  end

  always_comb begin
    nxt_paddr  = '0;
    nxt_cached = 1'b0;
    nxt_miss   = 1'b0;
    case (req_vaddr[31:29])
      3'b101: nxt_paddr = {3'b000, req_vaddr[28:0]};
      3'b100: begin
        nxt_paddr  = {3'b000, req_vaddr[28:0]};
        nxt_cached = (KSEG0_CACHED != 0);
      end
      default: begin
        if (hit) begin
          nxt_paddr  = {hit_pfn, req_vaddr[11:0]};
          nxt_cached = hit_c;
        end else begin
          nxt_miss = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_paddr  <= '0;
      resp_cached <= 1'b0;
      resp_miss   <= 1'b0;
      miss_count  <= '0;
    end else begin
      if (acc) begin
        resp_valid  <= 1'b1;
        resp_paddr  <= nxt_paddr;
        resp_cached <= nxt_cached;
        resp_miss   <= nxt_miss;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (resp_valid && resp_ready && resp_miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
endmodule

module mmu_tlb #(
  parameter int NUM_CH       = 2,
  parameter int TLB_ENTRIES  = 8,
  parameter int KSEG0_CACHED = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  mmu_tlb_if.slave                         bus,
  input  logic                             tlb_we,
  input  logic [$clog2(TLB_ENTRIES)-1:0]   tlb_index,
  input  logic [19:0]                      tlb_vpn,
  input  logic [19:0]                      tlb_pfn,
  input  logic                             tlb_v,
  input  logic                             tlb_c,
  input  logic                             tlb_flush,
  output logic [NUM_CH-1:0][15:0]          miss_count
);
  logic [TLB_ENTRIES-1:0][19:0] ent_vpn, ent_pfn;
  logic [TLB_ENTRIES-1:0]       ent_v, ent_c;

  // Flush wins over a same-cycle write, so the written entry lands invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ent_v <= '0;
    else if (tlb_flush)
      ent_v <= '0;
    else if (tlb_we)
      ent_v[tlb_index] <= tlb_v;
  end

  always_ff @(posedge clk) begin
    if (tlb_we) begin
      ent_vpn[tlb_index] <= tlb_vpn;
      ent_pfn[tlb_index] <= tlb_pfn;
      ent_c[tlb_index]   <= tlb_c;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mmu_tlb_ch #(
      .TLB_ENTRIES (TLB_ENTRIES),
      .KSEG0_CACHED(KSEG0_CACHED)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (bus.req_valid[g]),
      .req_vaddr  (bus.req_vaddr[g]),
      .req_ready  (bus.req_ready[g]),
      .resp_valid (bus.resp_valid[g]),
      .resp_ready (bus.resp_ready[g]),
      .resp_paddr (bus.resp_paddr[g]),
      .resp_cached(bus.resp_cached[g]),
      .resp_miss  (bus.resp_miss[g]),
      .miss_count (miss_count[g]),
      .ent_vpn    (ent_vpn),
      .ent_pfn    (ent_pfn),
      .ent_v      (ent_v),
      .ent_c      (ent_c)
    );
  end
endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: stimulus pushes expected results per channel, a negedge
// monitor pops and compares on every delivered response.
module tb_mmu_tlb;
  logic clk = 1'b0;
  logic rst;
  logic        tlb_we, tlb_v, tlb_c, tlb_flush;
  logic [2:0]  tlb_index;
  logic [19:0] tlb_vpn, tlb_pfn;
  logic [1:0][15:0] miss_count, nc_miss_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [31:0] pa; logic c; logic m; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  mmu_tlb_if #(.NUM_CH(2)) bus ();
  mmu_tlb_if #(.NUM_CH(2)) nc_if ();

  mmu_tlb #(.NUM_CH(2), .TLB_ENTRIES(8), .KSEG0_CACHED(1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_vpn(tlb_vpn), .tlb_pfn(tlb_pfn),
    .tlb_v(tlb_v), .tlb_c(tlb_c), .tlb_flush(tlb_flush), .miss_count(miss_count)
  );

  mmu_tlb #(.NUM_CH(2), .TLB_ENTRIES(8), .KSEG0_CACHED(0)) dut_nc (
    .clk(clk), .rst(rst), .bus(nc_if),
    .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_vpn(tlb_vpn), .tlb_pfn(tlb_pfn),
    .tlb_v(tlb_v), .tlb_c(tlb_c), .tlb_flush(tlb_flush), .miss_count(nc_miss_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every handshake must match the oldest expectation of its channel.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst && bus.resp_valid[c] && bus.resp_ready[c]) begin
        exp_t e;
        logic got;
        got = 1'b0;
        e   = '0;
        checks++;
        if (c == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (c == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        if (!got) begin
          failures++;
          $display("FAIL unexpected_resp ch%0d got pa=%h c=%b m=%b required none", c,
                   bus.resp_paddr[c], bus.resp_cached[c], bus.resp_miss[c]);
        end else if (bus.resp_paddr[c] !== e.pa || bus.resp_cached[c] !== e.c ||
                     bus.resp_miss[c] !== e.m) begin
          failures++;
          $display("FAIL resp ch%0d got pa=%h c=%b m=%b required pa=%h c=%b m=%b", c,
                   bus.resp_paddr[c], bus.resp_cached[c], bus.resp_miss[c], e.pa, e.c, e.m);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid   = '0;
    nc_if.req_valid = '0;
    tlb_we          = 1'b0;
    tlb_flush       = 1'b0;
  endtask

  task automatic issue(input int ch, input logic [31:0] va, input logic [31:0] pa,
                       input logic c, input logic m);
    exp_t e;
    e = '{pa: pa, c: c, m: m};
    bus.req_valid[ch] = 1'b1;
    bus.req_vaddr[ch] = va;
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic tlb_wr(input logic [2:0] idx, input logic [19:0] vpn, input logic [19:0] pfn,
                        input logic v, input logic c);
    tlb_we = 1'b1; tlb_index = idx; tlb_vpn = vpn; tlb_pfn = pfn; tlb_v = v; tlb_c = c;
  endtask

  initial begin
    rst = 1'b1;
    tlb_we = 1'b0; tlb_flush = 1'b0; tlb_index = '0; tlb_vpn = '0; tlb_pfn = '0;
    tlb_v = 1'b0; tlb_c = 1'b0;
    bus.req_valid = '0; bus.req_vaddr = '0; bus.resp_ready = 2'b11;
    nc_if.req_valid = '0; nc_if.req_vaddr = '0; nc_if.resp_ready = 2'b11;
    #2;
    chk("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd3);
    chk("rst_miss_count", miss_count, 32'd0);

    // Requests while in reset must not be accepted.
    bus.req_valid = 2'b11; bus.req_vaddr[0] = 32'hA000_0000; bus.req_vaddr[1] = 32'h0;
    tick(); tick();
    chk("rst_no_accept", {30'd0, bus.resp_valid}, 32'd0);
    rst = 1'b0; idle();
    tick();
    chk("post_rst_idle", {30'd0, bus.resp_valid}, 32'd0);

    // kseg1 / kseg0 windows and their boundaries
    issue(0, 32'hBFC0_0000, 32'h1FC0_0000, 1'b0, 1'b0);
    tick(); idle(); tick();
    issue(1, 32'h8000_1234, 32'h0000_1234, 1'b1, 1'b0);
    nc_if.req_valid[1] = 1'b1; nc_if.req_vaddr[1] = 32'h8000_1234;
    tick();
    chk("nc_valid", {31'd0, nc_if.resp_valid[1]}, 32'd1);
    chk("nc_paddr", nc_if.resp_paddr[1], 32'h0000_1234);
    chk("nc_cached", {31'd0, nc_if.resp_cached[1]}, 32'd0);
    idle(); tick();
    issue(0, 32'h9FFF_FFFF, 32'h1FFF_FFFF, 1'b1, 1'b0);
    issue(1, 32'hA000_0000, 32'h0000_0000, 1'b0, 1'b0);
    tick(); idle(); tick();

    // TLB hit on ch0 alongside a miss on ch1
    tlb_wr(3'd3, 20'h00400, 20'h01234, 1'b1, 1'b1);
    tick(); idle();
    issue(0, 32'h0040_0ABC, 32'h0123_4ABC, 1'b1, 1'b0);
    issue(1, 32'h0050_0000, 32'h0, 1'b0, 1'b1);
    tick(); idle(); tick(); tick();
    chk("miss_count1_first", {16'd0, miss_count[1]}, 32'd1);
    chk("miss_count0_first", {16'd0, miss_count[0]}, 32'd0);

    // Write and lookup in the same cycle: lookup sees the old (empty) entry
    tlb_wr(3'd2, 20'h00700, 20'h0ABCD, 1'b1, 1'b0);
    issue(0, 32'h0070_0010, 32'h0, 1'b0, 1'b1);
    tick(); idle();
    issue(0, 32'h0070_0010, 32'h0ABC_D010, 1'b0, 1'b0);
    tick(); idle();

    // Duplicate VPN: lowest index wins
    tlb_wr(3'd6, 20'h00123, 20'h66666, 1'b1, 1'b0);
    tick();
    tlb_wr(3'd1, 20'h00123, 20'h11111, 1'b1, 1'b1);
    tick(); idle();
    issue(0, 32'h0012_3456, 32'h1111_1456, 1'b1, 1'b0);
    tick(); idle();

    // Flush with concurrent write; same-cycle lookups still see pre-flush contents
    tlb_flush = 1'b1;
    tlb_wr(3'd5, 20'h00900, 20'h22222, 1'b1, 1'b1);
    issue(0, 32'h0040_0ABC, 32'h0123_4ABC, 1'b1, 1'b0);
    issue(1, 32'h0012_3FFF, 32'h1111_1FFF, 1'b1, 1'b0);
    tick(); idle();
    issue(0, 32'h0090_0000, 32'h0, 1'b0, 1'b1);
    issue(1, 32'h0040_0ABC, 32'h0, 1'b0, 1'b1);
    tick(); idle();
    issue(0, 32'h0070_0010, 32'h0, 1'b0, 1'b1);
    issue(1, 32'h0012_3000, 32'h0, 1'b0, 1'b1);
    tick(); idle();
    issue(0, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
    issue(1, 32'hC000_0000, 32'h0, 1'b0, 1'b1);
    tick(); idle(); tick(); tick();
    chk("miss_count0_mid", {16'd0, miss_count[0]}, 32'd4);
    chk("miss_count1_mid", {16'd0, miss_count[1]}, 32'd4);

    // Stall: result A held for 3 cycles while request B waits
    bus.resp_ready[0] = 1'b0;
    issue(0, 32'h8000_0010, 32'h0000_0010, 1'b1, 1'b0);
    tick();
    bus.req_vaddr[0] = 32'hA000_0020;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_ready", {31'd0, bus.req_ready[0]}, 32'd0);
      chk("stall_valid", {31'd0, bus.resp_valid[0]}, 32'd1);
      chk("stall_paddr", bus.resp_paddr[0], 32'h0000_0010);
      chk("stall_attr", {30'd0, bus.resp_cached[0], bus.resp_miss[0]}, 32'd2);
      tick();
    end
    bus.resp_ready[0] = 1'b1;
    issue(0, 32'hA000_0020, 32'h0000_0020, 1'b0, 1'b0);
    tick(); idle();
    chk("stall_second_valid", {31'd0, bus.resp_valid[0]}, 32'd1);
    chk("stall_second_paddr", bus.resp_paddr[0], 32'h0000_0020);
    tick();

    // Saturate ch1 miss counter: 4 + 65535 misses, clamps at 0xFFFF
    for (int i = 0; i < 65535; i++) begin
      issue(1, 32'h0000_0000, 32'h0, 1'b0, 1'b1);
      tick();
    end
    idle(); tick(); tick();
    chk("miss_count1_sat", {16'd0, miss_count[1]}, 32'h0000_FFFF);

    // Reset while a miss is stalled: discarded, nothing counted
    bus.resp_ready[0] = 1'b0;
    bus.req_valid[0] = 1'b1; bus.req_vaddr[0] = 32'h0;
    tick(); idle();
    chk("pre_rst_pending", {30'd0, bus.resp_valid[0], bus.resp_miss[0]}, 32'd3);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {30'd0, bus.resp_valid}, 32'd0);
    chk("rst_mid_paddr0", bus.resp_paddr[0], 32'd0);
    chk("rst_mid_attr", {28'd0, bus.resp_cached, bus.resp_miss}, 32'd0);
    chk("rst_mid_count", miss_count, 32'd0);
    chk("rst_mid_ready", {30'd0, bus.req_ready}, 32'd3);
    tick();
    chk("rst_next_valid", {30'd0, bus.resp_valid}, 32'd0);
    bus.resp_ready = 2'b11;
    rst = 1'b0;
    tick(); tick();
    chk("rst_after_count", miss_count, 32'd0);
    chk("sb_drained", q0.size() + q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
